cic_decim_ctrl: RTL

Control and sequencing block for the CIC decimation filter. It accepts input samples over a valid/ready handshake and strobes the integrator chain once per accepted sample. After every R-th sample it moves a decimated token through the comb pipeline using per-stage enables and backpressure, and presents the result on an output valid/ready handshake. It also owns the run/drain state, the decimation-ratio register and a sticky overflow status for the integrator datapath.

---
 rtl/cic_decim_ctrl_if.sv | 10 +
 rtl/cic_decim_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cic_decim_ctrl_if.sv
// Input and output sample handshakes of the CIC decimation controller.
interface cic_decim_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, input in_ready, input out_valid, output out_ready);
  modport slave  (input in_valid, output in_ready, output out_valid, input out_ready);
endinterface

// File: rtl/cic_decim_ctrl.sv
// Sequencer for a CIC decimator: integrator strobes, every-R-th token through a
// backpressured comb pipeline, run/drain control and sticky integrator overflow.
module cic_decim_ctrl #(
  parameter int RATE_W   = 8,
  parameter int N_STAGES = 3
) (
  input  logic                clk,
  input  logic                rst,
  cic_decim_ctrl_if.slave     hs,
  input  logic [RATE_W-1:0]   cfg_ratio,
  input  logic                cfg_load,
  input  logic                stop,
  output logic                integ_en,
  input  logic [N_STAGES-1:0] integ_ovf,
  output logic [N_STAGES-1:0] comb_en,
  output logic                dp_clr,
  output logic                ovf_sticky,
  input  logic                clr_ovf,
  output logic                cfg_err,
  output logic                busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [RATE_W-1:0]   ratio_q, ratio_d;
  logic [RATE_W-1:0]   cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [N_STAGES-1:0] v_q, v_d;
  logic                ovf_q, ovf_d;
  logic                dp_clr_q, dp_clr_d;
  logic                cfg_err_q, cfg_err_d;

  logic [N_STAGES:0]   comb_en_c;
  logic                s0_free;
  logic                in_ready_c;
  logic                accept;
  logic                dec_accept;

  // Enable chain resolved from the output backwards so a released out_ready
  // ripples through every stage within the same cycle.
  always_comb begin : comb_chain
    logic [N_STAGES:0] e;
    e = '0;
    e[N_STAGES] = hs.out_ready;
    for (int i = N_STAGES - 1; i >= 1; i--) begin
      e[i] = v_q[i-1] && (!v_q[i] || e[i+1]);
    end
    s0_free   = !v_q[0] || e[1];
    e[0]      = pend_q && s0_free;
    comb_en_c = e;
  end

  always_comb begin
    state_d   = state_q;
    ratio_d   = ratio_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    v_d       = v_q;
    dp_clr_d  = 1'b0;
    cfg_err_d = 1'b0;

    // Integrators are held off while the clear pulse is in flight.
    in_ready_c = (state_q == ST_RUN) && !dp_clr_q && (!pend_q || s0_free);
    accept     = hs.in_valid && in_ready_c;
    dec_accept = accept && (cnt_q == ratio_q - RATE_W'(1));

    if (accept) begin
      cnt_d = dec_accept ? '0 : cnt_q + RATE_W'(1);
    end

    if (comb_en_c[0]) begin
      pend_d = dec_accept;
    end else if (dec_accept) begin
      pend_d = 1'b1;
    end

    for (int i = 0; i < N_STAGES; i++) begin
      if (comb_en_c[i]) begin
        v_d[i] = 1'b1;
      end else if (comb_en_c[i+1]) begin
        v_d[i] = 1'b0;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          if (cfg_ratio != '0) begin
            ratio_d  = cfg_ratio;
            cnt_d    = '0;
            pend_d   = 1'b0;
            dp_clr_d = 1'b1;
            state_d  = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pend_q && (v_q == '0)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((|integ_ovf) && (state_q != ST_IDLE)) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ratio_q   <= RATE_W'(1);
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      v_q       <= '0;
      ovf_q     <= 1'b0;
      dp_clr_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ratio_q   <= ratio_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      v_q       <= v_d;
      ovf_q     <= ovf_d;
      dp_clr_q  <= dp_clr_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign hs.in_ready  = in_ready_c;
  assign hs.out_valid = v_q[N_STAGES-1];
  assign integ_en     = accept;
  assign comb_en      = comb_en_c[N_STAGES-1:0];
  assign dp_clr       = dp_clr_q;
  assign cfg_err      = cfg_err_q;
  assign ovf_sticky   = ovf_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
